morse_sequence_encoder: RTL and testbench
=========================================

Name: morse_sequence_encoder

Overview:
- Upstream neighbour of the sequence translator. Times a debounced Morse key input in clock ticks and classifies each press as a dot or a dash.
- Groups elements into characters at letter gaps and inserts space codes at word gaps.
- Packs up to 16 ten-bit character codes into the 160-bit sequences bus the translator consumes.
- Code format: 5 two-bit symbols, MSB-first. 00 = dot, 01 = dash, 10 = word space, 11 = pad. Examples: A = 0001111111, space = 1011111111, invalid/empty = 1111111111.

Parameters:
- CNT_W, 24, width of the mark and gap duration counters.
- DASH_TICKS, 3000000, a mark lasting at least this many cycles is a dash; shorter is a dot.
- LETTER_GAP_TICKS, 3000000, key-up cycles that close the current character.
- WORD_GAP_TICKS, 7000000, key-up cycles that emit a word space. Must be greater than LETTER_GAP_TICKS.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- key_in  input  1  debounced, already-synchronised key level; 1 = pressed.
- flush  input  1  single-cycle request to emit a partially filled buffer.
- sequences  output  160  packed codes; slot k occupies bits [159-10k : 150-10k].
- seq_valid  output  1  one-cycle pulse when sequences has been updated.
- char_count  output  5  number of characters committed into the current (unemitted) buffer, 0..15.

Behaviour:
- Only clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: sequences all 1s, seq_valid 0, char_count 0. Internal state after reset: buffer all 1s, element register all 1s, elem_cnt 0, invalid flag 0, state IDLE, both counters 0.
- key_in is registered once (key_r). All timing uses key_r.
- Counters saturate at 2^CNT_W-1 and never wrap.
- FSM states:
  - IDLE: no character pending. key_r=1 -> MARK with mark_cnt=1.
  - MARK: mark_cnt increments each cycle key_r=1.
    - On key_r=0, classify: mark_cnt>=DASH_TICKS gives 01, otherwise 00.
    - If elem_cnt<5, write the symbol into slot elem_cnt of the element register and increment elem_cnt. Otherwise set the invalid flag.
    - Then go to SPACE with gap_cnt=1.
  - SPACE: gap_cnt increments while key_r=0.
    - key_r=1 -> MARK; the same character continues.
    - gap_cnt==LETTER_GAP_TICKS -> commit the character, go to WGAP.
  - WGAP: gap_cnt keeps counting.
    - key_r=1 -> MARK; a new character starts and no space is inserted.
    - gap_cnt==WORD_GAP_TICKS -> commit 1011111111, go to IDLE.
- IDLE never emits repeated spaces.
- Character commit:
  - The committed code is the element register, or 1111111111 if the invalid flag is set.
  - The element register resets to all 1s; elem_cnt and the invalid flag clear.
- Buffer write:
  - A commit writes slot char_count, then char_count increments.
  - A commit into slot 15 triggers emission.
- Emission:
  - On the next edge, sequences takes the buffer contents, including the character just committed.
  - seq_valid is high for exactly that one cycle.
  - The buffer refills with all 1s and char_count returns to 0.
- flush:
  - When char_count>0, or a commit occurs in the same cycle, flush causes emission. The same-cycle commit is included first.
  - When char_count==0 and no commit is occurring, flush is ignored.
  - A character still being keyed (MARK or SPACE) is not committed by flush and stays pending.
  - Unfilled slots remain 1111111111.
- sequences holds its value between emissions.
- Latency: one cycle from key_in to key_r. Commit and emission happen on the same edge, with seq_valid visible in the following cycle.
- A reset asserted mid-operation discards the pending character and the buffer. No seq_valid is produced.

Test Plan:
All scenarios use DASH_TICKS=4, LETTER_GAP_TICKS=4, WORD_GAP_TICKS=10.
1. Press 2 cycles, release 5 cycles, pulse flush -> seq_valid for 1 cycle; sequences[159:150]=0011111111 (E); bits [149:0] all 1s; char_count returns to 0.
2. Press 2, release 2, press 6, release 5, flush -> slot0=0001111111 (A).
3. Press 6, release 2, press 2, release 2, press 6, release 2, press 2, release 5, flush -> slot0=0100010011 (C). Check boundary: press exactly 3 cycles -> dot, exactly 4 -> dash.
4. Dot; release 12 cycles; press 6; release 5; flush -> slot0=0011111111, slot1=1011111111, slot2=0111111111. Then 30 more idle cycles -> no additional space commit, char_count stays at the post-flush value 0.
5. Six dots each separated by 2-cycle gaps, then release 5 -> committed code 1111111111; char_count=1.
6. Sixteen E characters with 5-cycle gaps -> automatic emission with no flush; all slots 0011111111.
7. Assert rst during a press held for 3 cycles -> no commit and seq_valid stays 0. A flush afterwards is ignored.

Source files
------------

// File: rtl/morse_sequence_encoder.sv
// Morse sequence encoder.
//
// Times a debounced Morse key in clock ticks, classifies each mark as a dot
// or a dash, groups elements into characters at letter gaps and inserts a
// word-space code at word gaps. Committed 10-bit character codes are packed
// into a 16-slot buffer. The buffer is emitted on the 160-bit sequences bus
// when slot 15 fills, or earlier on a flush request.
//
// Code format: five 2-bit symbols, MSB first.
//   00 = dot, 01 = dash, 10 = word space, 11 = pad.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous, active-high reset
//   key_in_i      debounced, synchronised key level (1 = pressed)
//   flush_i       single-cycle request to emit a partially filled buffer
//   sequences_o   packed codes, slot k at bits [159-10k : 150-10k]
//   seq_valid_o   one-cycle pulse when sequences_o has been updated
//   char_count_o  characters committed into the current buffer (0..15)

module morse_sequence_encoder #(
  parameter int unsigned CNT_W            = 24,
  parameter int unsigned DASH_TICKS       = 3000000,
  parameter int unsigned LETTER_GAP_TICKS = 3000000,
  parameter int unsigned WORD_GAP_TICKS   = 7000000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         key_in_i,
  input  logic         flush_i,
  output logic [159:0] sequences_o,
  output logic         seq_valid_o,
  output logic [4:0]   char_count_o
);

  localparam logic [CNT_W-1:0] DashThr   = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] LetterThr = CNT_W'(LETTER_GAP_TICKS);
  localparam logic [CNT_W-1:0] WordThr   = CNT_W'(WORD_GAP_TICKS);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [9:0]       SpaceCode = 10'b1011111111;
  localparam logic [9:0]       EmptyCode = 10'b1111111111;

  typedef enum logic [1:0] {
    StIdle,
    StMark,
    StSpace,
    StWgap
  } state_e;

  // Saturating increment: counters hold at all-ones rather than wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  // Registered state
  state_e           state_q,      state_d;
  logic             key_q;
  logic [CNT_W-1:0] mark_cnt_q,   mark_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q,    gap_cnt_d;
  logic [9:0]       elem_q,       elem_d;
  logic [2:0]       elem_cnt_q,   elem_cnt_d;
  logic             invalid_q,    invalid_d;
  logic [159:0]     buf_q,        buf_d;
  logic [4:0]       char_count_q, char_count_d;
  logic [159:0]     seq_q,        seq_d;
  logic             seq_valid_q,  seq_valid_d;

  // Combinational helpers
  logic       commit;
  logic [9:0] commit_code;
  logic [1:0] sym;
  logic       emit;

  // Character FSM: timing, classification and character commit.
  always_comb begin
    state_d     = state_q;
    mark_cnt_d  = mark_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    elem_d      = elem_q;
    elem_cnt_d  = elem_cnt_q;
    invalid_d   = invalid_q;
    commit      = 1'b0;
    commit_code = EmptyCode;
    sym         = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (key_q) begin
          state_d    = StMark;
          mark_cnt_d = CntOne;
        end
      end

      StMark: begin
        if (key_q) begin
          mark_cnt_d = sat_inc(mark_cnt_q);
        end else begin
          sym = (mark_cnt_q >= DashThr) ? 2'b01 : 2'b00;
          // A sixth element cannot be encoded; poison the character instead.
          case (elem_cnt_q)
            3'd0:    elem_d[9:8] = sym;
            3'd1:    elem_d[7:6] = sym;
            3'd2:    elem_d[5:4] = sym;
            3'd3:    elem_d[3:2] = sym;
            3'd4:    elem_d[1:0] = sym;
            default: invalid_d   = 1'b1;
          endcase
          if (elem_cnt_q < 3'd5) begin
            elem_cnt_d = elem_cnt_q + 3'd1;
          end
          state_d   = StSpace;
          gap_cnt_d = CntOne;
        end
      end

      StSpace: begin
        if (key_q) begin
          state_d    = StMark;
          mark_cnt_d = CntOne;
        end else if (gap_cnt_q == LetterThr) begin
          commit      = 1'b1;
          commit_code = invalid_q ? EmptyCode : elem_q;
          elem_d      = EmptyCode;
          elem_cnt_d  = 3'd0;
          invalid_d   = 1'b0;
          gap_cnt_d   = sat_inc(gap_cnt_q);
          state_d     = StWgap;
        end else begin
          gap_cnt_d = sat_inc(gap_cnt_q);
        end
      end

      StWgap: begin
        if (key_q) begin
          state_d    = StMark;
          mark_cnt_d = CntOne;
        end else if (gap_cnt_q == WordThr) begin
          commit      = 1'b1;
          commit_code = SpaceCode;
          gap_cnt_d   = '0;
          state_d     = StIdle;
        end else begin
          gap_cnt_d = sat_inc(gap_cnt_q);
        end
      end

      default: state_d = StIdle;
    endcase

    // Buffer write and emission. A same-cycle commit lands in the buffer
    // before the buffer is copied out.
    buf_d        = buf_q;
    char_count_d = char_count_q;
    seq_d        = seq_q;
    seq_valid_d  = 1'b0;

    if (commit) begin
      for (int k = 0; k < 16; k++) begin
        if (char_count_q == 5'(k)) begin
          buf_d[159-10*k -: 10] = commit_code;
        end
      end
    end

    emit = (commit && (char_count_q == 5'd15)) ||
           (flush_i && (commit || (char_count_q != 5'd0)));

    if (emit) begin
      seq_d        = buf_d;
      seq_valid_d  = 1'b1;
      buf_d        = {160{1'b1}};
      char_count_d = 5'd0;
      // A flush closes the message: the trailing word gap would only put a
      // lone space at the head of the next buffer, so drop it.
      if (flush_i && (state_d == StWgap)) begin
        state_d = StIdle;
      end
    end else if (commit) begin
      char_count_d = char_count_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      key_q        <= 1'b0;
      mark_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      elem_q       <= EmptyCode;
      elem_cnt_q   <= 3'd0;
      invalid_q    <= 1'b0;
      buf_q        <= {160{1'b1}};
      char_count_q <= 5'd0;
      seq_q        <= {160{1'b1}};
      seq_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_in_i;
      mark_cnt_q   <= mark_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      elem_q       <= elem_d;
      elem_cnt_q   <= elem_cnt_d;
      invalid_q    <= invalid_d;
      buf_q        <= buf_d;
      char_count_q <= char_count_d;
      seq_q        <= seq_d;
      seq_valid_q  <= seq_valid_d;
    end
  end

  assign sequences_o  = seq_q;
  assign seq_valid_o  = seq_valid_q;
  assign char_count_o = char_count_q;

endmodule

// File: tb/tb_morse_sequence_encoder.sv
// Directed testbench for morse_sequence_encoder with short timing parameters
// (dash >= 4 ticks, letter gap 4, word gap 10).

module tb_morse_sequence_encoder;

  localparam logic [9:0] CodeE   = 10'b0011111111;
  localparam logic [9:0] CodeA   = 10'b0001111111;
  localparam logic [9:0] CodeC   = 10'b0100010011;
  localparam logic [9:0] CodeT   = 10'b0111111111;
  localparam logic [9:0] CodeSp  = 10'b1011111111;
  localparam logic [9:0] CodeInv = 10'b1111111111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_in = 1'b0;
  logic         flush = 1'b0;
  logic [159:0] sequences;
  logic         seq_valid;
  logic [4:0]   char_count;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int p0;

  always #5 clk = ~clk;

  morse_sequence_encoder #(
    .CNT_W           (24),
    .DASH_TICKS      (4),
    .LETTER_GAP_TICKS(4),
    .WORD_GAP_TICKS  (10)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_in_i    (key_in),
    .flush_i     (flush),
    .sequences_o (sequences),
    .seq_valid_o (seq_valid),
    .char_count_o(char_count)
  );

  // Counts seq_valid cycles seen at each rising edge.
  always @(posedge clk) begin
    if (seq_valid) pulses <= pulses + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int n);
    key_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic key_up(input int n);
    key_in = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    key_in = 1'b0;
    flush  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_sequences", sequences, {160{1'b1}});
    chk("rst_seq_valid", 160'(seq_valid), 160'd0);
    chk("rst_char_count", 160'(char_count), 160'd0);

    // 1: single dot -> E
    p0 = pulses;
    press(2);
    key_up(5);
    do_flush();
    chk("t1_valid", 160'(seq_valid), 160'd1);
    chk("t1_slot0", 160'(sequences[159:150]), 160'(CodeE));
    chk("t1_rest", {10'b0, sequences[149:0]}, {10'b0, {150{1'b1}}});
    chk("t1_count", 160'(char_count), 160'd0);
    step();
    chk("t1_valid_drop", 160'(seq_valid), 160'd0);
    chk("t1_pulses", 160'(pulses - p0), 160'd1);

    // 2: dot dash -> A
    do_reset();
    press(2); key_up(2); press(6); key_up(5);
    do_flush();
    chk("t2_valid", 160'(seq_valid), 160'd1);
    chk("t2_slot0", 160'(sequences[159:150]), 160'(CodeA));
    chk("t2_count", 160'(char_count), 160'd0);

    // 3: dash dot dash dot -> C
    do_reset();
    press(6); key_up(2); press(2); key_up(2);
    press(6); key_up(2); press(2); key_up(5);
    do_flush();
    chk("t3_valid", 160'(seq_valid), 160'd1);
    chk("t3_slot0", 160'(sequences[159:150]), 160'(CodeC));

    // 3b: 3-tick mark is a dot, 4-tick mark is a dash -> A
    do_reset();
    press(3); key_up(2); press(4); key_up(5);
    do_flush();
    chk("t3b_valid", 160'(seq_valid), 160'd1);
    chk("t3b_slot0", 160'(sequences[159:150]), 160'(CodeA));

    // 4: E, word gap, T; no trailing space after flush
    do_reset();
    p0 = pulses;
    press(2); key_up(12); press(6); key_up(5);
    chk("t4_count_pre", 160'(char_count), 160'd2);
    do_flush();
    chk("t4_valid", 160'(seq_valid), 160'd1);
    chk("t4_seq", sequences, {CodeE, CodeSp, CodeT, {130{1'b1}}});
    repeat (30) step();
    chk("t4_count_idle", 160'(char_count), 160'd0);
    chk("t4_pulses", 160'(pulses - p0), 160'd1);

    // 5: E then six dots -> invalid code
    do_reset();
    press(2); key_up(6);
    for (int i = 0; i < 6; i++) begin
      press(2);
      if (i < 5) key_up(2);
    end
    key_up(6);
    chk("t5_count", 160'(char_count), 160'd2);
    do_flush();
    chk("t5_valid", 160'(seq_valid), 160'd1);
    chk("t5_seq", sequences, {CodeE, CodeInv, {140{1'b1}}});

    // 6: sixteen E -> automatic emission
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 16; i++) begin
      press(2);
      key_up(5);
    end
    chk("t6_count15", 160'(char_count), 160'd15);
    chk("t6_no_early", 160'(pulses - p0), 160'd0);
    step();
    chk("t6_valid", 160'(seq_valid), 160'd1);
    chk("t6_seq", sequences, {16{CodeE}});
    chk("t6_count0", 160'(char_count), 160'd0);

    // 7: reset during a press discards it; flush afterwards is ignored
    do_reset();
    p0 = pulses;
    key_in = 1'b1;
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    key_up(10);
    chk("t7_count", 160'(char_count), 160'd0);
    chk("t7_no_pulse", 160'(pulses - p0), 160'd0);
    do_flush();
    step();
    chk("t7_flush_ignored", 160'(pulses - p0), 160'd0);
    chk("t7_count_after", 160'(char_count), 160'd0);
    chk("t7_seq", sequences, {160{1'b1}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
